romix_param: RTL and testbench

- Parametrised scrypt ROMix engine: next generation of the fixed-size ROMix.
- Generic block factor R (data width 1024*R) and cost N = 2^LOG2_N.
- Adds ready/valid handshakes on input and output; BlockMix is an external core driven through a start/done handshake.
- Holds the V scratchpad internally; sits between the PBKDF2 front-end and the PBKDF2 back-end in each scrypt lane.

---
 rtl/romix_pkg.sv | 21 ++
 rtl/romix_spad.sv | 25 ++
 rtl/romix_param.sv | 160 ++++++++++++++++
 tb/tb_romix_param.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/romix_pkg.sv
// Shared types and constants for the parametrised scrypt ROMix engine.
package romix_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL_WR   = 3'd1,
    FILL_WAIT = 3'd2,
    MIX_RD    = 3'd3,
    MIX_RDW   = 3'd4,
    MIX_WAIT  = 3'd5,
    DONE      = 3'd6
  } romix_state_e;

  // Bit offset of Integerify's source word, measured down from the top of X.
  localparam int unsigned INTEGERIFY_OFS = 512;

  function automatic int unsigned data_w(input int unsigned r);
    return 1024 * r;
  endfunction

endpackage

// File: rtl/romix_spad.sv
// V scratchpad: single-port synchronous RAM, 1-cycle read, read returns old data.
module romix_spad
  import romix_pkg::*;
#(
  parameter int unsigned W  = data_w(1),
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/romix_param.sv
// Parametrised scrypt ROMix engine with ready/valid I/O and an external BlockMix core.
// Optional cycle counter output enabled by defining ROMIX_CYCLE_CNT_EN.
module romix_param
  import romix_pkg::*;
#(
  parameter int unsigned  R      = 1,
  parameter int unsigned  LOG2_N = 10,
  localparam int unsigned W      = data_w(R)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         bm_start,
  output logic [W-1:0] bm_in,
  input  logic         bm_done,
  input  logic [W-1:0] bm_out,
  output logic         busy
`ifdef ROMIX_CYCLE_CNT_EN
  ,
  output logic [31:0]  cyc_cnt
`endif
);

  localparam int unsigned J_OFS = W - INTEGERIFY_OFS;
  localparam logic [LOG2_N-1:0] I_LAST = '1;

  romix_state_e        state_q, state_d;
  logic [W-1:0]        x_q, x_d;
  logic [LOG2_N-1:0]   i_q, i_d;
  logic [W-1:0]        bm_in_d, out_data_d;
  logic                bm_start_d;

  logic                ram_we, ram_re;
  logic [LOG2_N-1:0]   ram_addr;
  logic [W-1:0]        ram_wdata, ram_rdata;

  romix_spad #(.W(W), .AW(LOG2_N)) u_spad (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      i_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      bm_start  <= 1'b0;
      bm_in     <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      i_q       <= i_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      out_data  <= out_data_d;
      bm_start  <= bm_start_d;
      bm_in     <= bm_in_d;
      busy      <= (state_d != IDLE);
    end
  end

  // V[j] is fetched on the edge that produces the new X, so it is ready in MIX_RD
  // and bm_start/bm_in can be registered into MIX_RDW.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    i_d        = i_q;
    bm_in_d    = bm_in;
    bm_start_d = 1'b0;
    out_data_d = out_data;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = i_q;
    ram_wdata  = x_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d        = in_data;
          i_d        = '0;
          bm_in_d    = in_data;
          bm_start_d = 1'b1;
          state_d    = FILL_WR;
        end
      end
      FILL_WR: begin
        ram_we  = 1'b1;
        state_d = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (bm_done) begin
          x_d = bm_out;
          if (i_q == I_LAST) begin
            i_d      = '0;
            ram_re   = 1'b1;
            ram_addr = bm_out[J_OFS +: LOG2_N];
            state_d  = MIX_RD;
          end else begin
            i_d        = i_q + LOG2_N'(1);
            bm_in_d    = bm_out;
            bm_start_d = 1'b1;
            state_d    = FILL_WR;
          end
        end
      end
      MIX_RD: begin
        bm_in_d    = x_q ^ ram_rdata;
        bm_start_d = 1'b1;
        state_d    = MIX_RDW;
      end
      MIX_RDW: begin
        state_d = MIX_WAIT;
      end
      MIX_WAIT: begin
        if (bm_done) begin
          x_d = bm_out;
          if (i_q == I_LAST) begin
            out_data_d = bm_out;
            state_d    = DONE;
          end else begin
            i_d      = i_q + LOG2_N'(1);
            ram_re   = 1'b1;
            ram_addr = bm_out[J_OFS +: LOG2_N];
            state_d  = MIX_RD;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ROMIX_CYCLE_CNT_EN
  // Counts working cycles of the current block; saturates, holds in IDLE/DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt <= '0;
    end else if (state_q == IDLE) begin
      if (in_valid) cyc_cnt <= '0;
    end else if (state_q != DONE && cyc_cnt != 32'hFFFF_FFFF) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_romix_param.sv
// Directed bench for romix_param (R=1, LOG2_N=2) with a 3-cycle BlockMix stub.
module tb_romix_param;

  localparam int unsigned R      = 1;
  localparam int unsigned LOG2_N = 2;
  localparam int unsigned W      = 1024;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid, in_ready, out_valid, out_ready, bm_start, bm_done, busy;
  logic [W-1:0] in_data, out_data, bm_in, bm_out;
`ifdef ROMIX_CYCLE_CNT_EN
  logic [31:0]  cyc_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic         stub_inc;
  logic [2:0]   bm_pipe = '0;
  logic [W-1:0] start_log[$];

  always #5 clk = ~clk;

  // BlockMix stub: done 3 cycles after start, result is bm_in (+1 when stub_inc).
  always @(posedge clk) bm_pipe <= {bm_pipe[1:0], bm_start};
  assign bm_done = bm_pipe[2];
  assign bm_out  = stub_inc ? bm_in + W'(1) : bm_in;

  always @(posedge clk) if (bm_start) start_log.push_back(bm_in);

  romix_param #(.R(R), .LOG2_N(LOG2_N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .bm_start  (bm_start),
    .bm_in     (bm_in),
    .bm_done   (bm_done),
    .bm_out    (bm_out),
    .busy      (busy)
`ifdef ROMIX_CYCLE_CNT_EN
    ,
    .cyc_cnt   (cyc_cnt)
`endif
  );

  task automatic do_accept(input logic [W-1:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int start, output int cyc);
    cyc = start;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL out_valid_timeout: no out_valid within %0d cycles", cyc);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, bm_start, busy} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got rdy/vld/start/busy=%b want 1000", {in_ready, out_valid, bm_start, busy});
    end
    n_cmp++;
    if (out_data !== '0 || bm_in !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got out_data[63:0]=%h bm_in[63:0]=%h want 0", out_data[63:0], bm_in[63:0]);
    end
`ifdef ROMIX_CYCLE_CNT_EN
    n_cmp++;
    if (cyc_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cyc_cnt: got %0d want 0", cyc_cnt); end
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc;
    stub_inc = 1'b1;
    do_accept('0);
    wait_out(1, cyc);
    n_cmp++;
    if (cyc !== 37) begin n_bad++; $display("FAIL basic_latency: got %0d want 37", cyc); end
    n_cmp++;
    if (out_data !== W'(8)) begin
      n_bad++;
      $display("FAIL basic_result: got hi=%h lo=%h want lo=8", out_data[575:512], out_data[63:0]);
    end
    n_cmp++;
    if ({in_ready, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL basic_done_flags: got in_ready/busy=%b want 01", {in_ready, busy});
    end
`ifdef ROMIX_CYCLE_CNT_EN
    n_cmp++;
    if (cyc_cnt !== 32'd36) begin n_bad++; $display("FAIL basic_cyc_cnt: got %0d want 36", cyc_cnt); end
`endif
    consume();
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL basic_idle: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
    end
`ifdef ROMIX_CYCLE_CNT_EN
    n_cmp++;
    if (cyc_cnt !== 32'd36) begin n_bad++; $display("FAIL idle_cyc_cnt_hold: got %0d want 36", cyc_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    int cyc;
    stub_inc = 1'b1;
    do_accept('0);
    wait_out(1, cyc);
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b10 || out_data !== W'(8)) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got vld/rdy=%b data_lo=%h want 10 data_lo=8", k, {out_valid, in_ready}, out_data[63:0]);
      end
`ifdef ROMIX_CYCLE_CNT_EN
      n_cmp++;
      if (cyc_cnt !== 32'd36) begin n_bad++; $display("FAIL bp_cyc_cnt[%0d]: got %0d want 36", k, cyc_cnt); end
`endif
      @(negedge clk);
    end
    consume();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL bp_release: got rdy/vld=%b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_busy_input();
    int cyc;
    logic [W-1:0] other;
    other = '0;
    other[63:0] = 64'hA5A5_5A5A_1234_5678;
    other[575:512] = 64'h0000_0000_0000_0003;
    stub_inc = 1'b1;
    do_accept('0);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL busy_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b1;
    in_data  = other;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(3, cyc);
    n_cmp++;
    if (cyc !== 37 || out_data !== W'(8)) begin
      n_bad++;
      $display("FAIL busy_ignore: got lat=%0d data_lo=%h want lat=37 data_lo=8", cyc, out_data[63:0]);
    end
    consume();
  endtask

  task automatic test_index_select();
    int cyc;
    int base;
    logic [W-1:0] b;
    logic [W-1:0] exp_mix [4];
    b = '0;
    b[31:0]    = 32'hDEAD_BEEF;
    b[543:512] = 32'h0000_0007;
    exp_mix[0] = '0;
    exp_mix[1] = b;
    exp_mix[2] = '0;
    exp_mix[3] = b;
    stub_inc = 1'b0;
    base = start_log.size();
    do_accept(b);
    wait_out(1, cyc);
    n_cmp++;
    if (out_data !== b) begin
      n_bad++;
      $display("FAIL idx_result: got hi=%h lo=%h want hi=%h lo=%h", out_data[575:512], out_data[63:0], b[575:512], b[63:0]);
    end
    n_cmp++;
    if (start_log.size() !== base + 8) begin
      n_bad++;
      $display("FAIL idx_start_count: got %0d want 8", start_log.size() - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (start_log[base + 4 + k] !== exp_mix[k]) begin
          n_bad++;
          $display("FAIL idx_mix_operand[%0d]: got hi=%h lo=%h want hi=%h lo=%h", k,
                   start_log[base + 4 + k][575:512], start_log[base + 4 + k][63:0],
                   exp_mix[k][575:512], exp_mix[k][63:0]);
        end
      end
    end
    consume();
    stub_inc = 1'b1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    stub_inc = 1'b1;
    do_accept('0);
    repeat (18) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, bm_start, busy} !== 4'b1000 || out_data !== '0 || bm_in !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_vals: got rdy/vld/start/busy=%b bm_in_lo=%h", {in_ready, out_valid, bm_start, busy}, bm_in[63:0]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, bm_start, busy} !== 4'b1000 || bm_in !== '0) begin
      n_bad++;
      $display("FAIL stale_done_ignored: got rdy/vld/start/busy=%b bm_in_lo=%h", {in_ready, out_valid, bm_start, busy}, bm_in[63:0]);
    end
`ifdef ROMIX_CYCLE_CNT_EN
    n_cmp++;
    if (cyc_cnt !== 32'd0) begin n_bad++; $display("FAIL mid_cyc_cnt: got %0d want 0", cyc_cnt); end
`endif
    do_accept('0);
    wait_out(1, cyc);
    n_cmp++;
    if (cyc !== 37 || out_data !== W'(8)) begin
      n_bad++;
      $display("FAIL rerun_result: got lat=%0d data_lo=%h want lat=37 data_lo=8", cyc, out_data[63:0]);
    end
    consume();
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    stub_inc  = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_busy_input();
    test_index_select();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
